// File: rtl/cic3_pkg.sv
// Shared constants and monitor-select codes for the third-order CIC decimator.
package cic3_pkg;

  localparam int unsigned CIC_ORDER  = 3;
  localparam int unsigned DECIM_LOG2 = 8;
  localparam int unsigned OUT_W      = 25;

  // Monitor select codes; any code above MON_IN reads as zero.
  typedef enum logic [3:0] {
    MON_Y   = 4'd0,
    MON_I1  = 4'd1,
    MON_I2  = 4'd2,
    MON_I3  = 4'd3,
    MON_D1  = 4'd4,
    MON_D2  = 4'd5,
    MON_CNT = 4'd6,
    MON_IN  = 4'd7
  } mon_sel_e;

endpackage

// File: rtl/cic_integrator.sv
// One integrator stage: OUT_W-bit wrapping accumulator with enable.
module cic_integrator
  import cic3_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [OUT_W-1:0] add_i,
  output logic [OUT_W-1:0] acc_o
);

  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;

  // Next accumulator value; modulo 2^OUT_W wrap is intended.
  always_comb begin
    acc_d = acc_q;
    if (en_i) acc_d = acc_q + add_i;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic3_decimator.sv
// Third-order CIC decimator (ratio 256): 1-bit sigma-delta in, 25-bit PCM out,
// with a debug monitor mux onto the output bus.
module cic3_decimator
  import cic3_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  input  logic [3:0]       digital_monitor_sel,
  output logic [OUT_W-1:0] out
);

  // integ[0] is the zero-extended input bit; integ[k] is integrator k output.
  logic [CIC_ORDER:0][OUT_W-1:0]   integ;
  logic [CIC_ORDER-1:0][OUT_W-1:0] dly_q;
  logic [CIC_ORDER-1:0][OUT_W-1:0] dly_d;
  logic [CIC_ORDER-1:0][OUT_W-1:0] diff;
  logic [OUT_W-1:0]                y_q;
  logic [OUT_W-1:0]                y_d;
  logic [DECIM_LOG2-1:0]           cnt_q;
  logic [DECIM_LOG2-1:0]           cnt_d;
  logic                            strobe;

  assign integ[0] = OUT_W'(in);

  // Integrator cascade: each stage adds the previous stage's registered value.
  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_integ
    cic_integrator u_integ (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (1'b1),
      .add_i   (integ[k]),
      .acc_o   (integ[k+1])
    );
  end

  assign cnt_d  = cnt_q + 1'b1;
  assign strobe = &cnt_q;

  // Comb chain: all differences settle combinationally within the strobe cycle.
  always_comb begin
    diff  = '0;
    dly_d = dly_q;
    y_d   = y_q;
    diff[0] = integ[CIC_ORDER] - dly_q[0];
    for (int unsigned k = 1; k < CIC_ORDER; k++) begin
      diff[k] = diff[k-1] - dly_q[k];
    end
    if (strobe) begin
      dly_d[0] = integ[CIC_ORDER];
      for (int unsigned k = 1; k < CIC_ORDER; k++) begin
        dly_d[k] = diff[k-1];
      end
      y_d = diff[CIC_ORDER-1];
    end
  end

  // Decimation counter, comb delay lines and output sample register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      dly_q <= '0;
      y_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      dly_q <= dly_d;
      y_q   <= y_d;
    end
  end

  // Monitor mux: combinational view of registered nodes (plus the live input bit).
  always_comb begin
    out = '0;
    case (mon_sel_e'(digital_monitor_sel))
      MON_Y:   out = y_q;
      MON_I1:  out = integ[1];
      MON_I2:  out = integ[2];
      MON_I3:  out = integ[3];
      MON_D1:  out = dly_q[0];
      MON_D2:  out = dly_q[1];
      MON_CNT: out = OUT_W'(cnt_q);
      MON_IN:  out = OUT_W'(in);
      default: out = '0;
    endcase
  end

endmodule

// File: tb/tb_cic3_decimator.sv
// Scoreboard bench for cic3_decimator: exact cumulative-sum reference with a
// closed-form third difference at each decimation instant.
module tb_cic3_decimator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_b = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [24:0] out_w;

  cic3_decimator dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in                  (in_b),
    .digital_monitor_sel (sel),
    .out                 (out_w)
  );

  always #30 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: exact (non-wrapping) running sums and decimated samples.
  longint i1 = 0, i2 = 0, i3 = 0;
  longint s_hist[$];
  longint y_last = 0, d1_m = 0, d2_m = 0;
  int     n = 0;
  logic [24:0] exp_q[$];
  logic [24:0] cur_y = '0;

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  function automatic longint s_at(input int k);
    if (k < 0) return 0;
    return s_hist[k];
  endfunction

  // Advance the reference by one clock edge with input bit b.
  task automatic model_edge(input bit b);
    int j;
    if (n % 256 == 255) begin
      s_hist.push_back(i3);
      j      = s_hist.size() - 1;
      y_last = s_at(j) - 3 * s_at(j-1) + 3 * s_at(j-2) - s_at(j-3);
      d1_m   = s_at(j);
      d2_m   = s_at(j) - s_at(j-1);
      exp_q.push_back(y_last[24:0]);
    end
    i3 = i3 + i2;
    i2 = i2 + i1;
    i1 = i1 + longint'(b);
    n++;
  endtask

  task automatic step(input bit b);
    in_b = b;
    @(posedge clk);
    model_edge(b);
    #1;
  endtask

  function automatic logic [24:0] expect_mon(input int code);
    case (code)
      0: return y_last[24:0];
      1: return i1[24:0];
      2: return i2[24:0];
      3: return i3[24:0];
      4: return d1_m[24:0];
      5: return d2_m[24:0];
      6: return 25'(n % 256);
      7: return 25'(in_b);
      default: return '0;
    endcase
  endfunction

  // Walk every select code within one clock phase.
  task automatic sweep(input string tag);
    for (int c = 0; c < 16; c++) begin
      sel = 4'(c);
      #1;
      chk($sformatf("%s_sel%0d", tag, c), out_w, expect_mon(c));
    end
    sel = 4'd0;
  endtask

  // Assert reset asynchronously, check the cleared state, release after two edges.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    i1 = 0; i2 = 0; i3 = 0; n = 0;
    y_last = 0; d1_m = 0; d2_m = 0;
    s_hist.delete();
    exp_q.delete();
    #1;
    sweep(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: consume one expected sample per decimation period, check Y every cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      cur_y = '0;
    end else begin
      if (n > 0 && n % 256 == 0) begin
        if (exp_q.size() == 0) chk("sb_underflow", 25'd1, 25'd0);
        else                   cur_y = exp_q.pop_front();
      end
      if (sel == 4'd0) chk("y_stream", out_w, cur_y);
    end
  end

  initial begin
    // Reset with in=1 so code 7 is distinguishable from zero.
    in_b = 1'b1;
    do_reset("rst0");

    // in=0: output stays zero; counter visible across its wrap.
    for (int k = 0; k < 600; k++) begin
      step(1'b0);
      if (n >= 250 && n <= 262) begin
        sel = 4'd6;
        #1;
        chk("cnt_view", out_w, 25'(n % 256));
        sel = 4'd0;
      end
      if (n % 256 == 7) chk("zero_out", out_w, 25'd0);
    end

    // Random bitstream.
    for (int k = 0; k < 1500; k++) step(1'($urandom_range(0, 1)));
    sweep("rand1");

    // Mid-run reset while in=1.
    for (int k = 0; k < 300; k++) step(1'b1);
    do_reset("rst_mid");

    // in=1 long enough for I3 to wrap; output pinned at full scale.
    for (int k = 0; k < 10000; k++) begin
      step(1'b1);
      if (n >= 1280 && n % 256 == 7) chk("dc_full", out_w, 25'd16777216);
    end
    if (i3 < 64'sd33554432) chk("i3_wrap_reached", 25'd0, 25'd1);
    sweep("wrap");

    // Alternating 1,0,1,0 from reset release: half scale.
    do_reset("rst_alt");
    for (int k = 0; k < 3000; k++) begin
      step((n % 2) == 0);
      if (n >= 1280 && n % 256 == 7) chk("dc_half", out_w, 25'd8388608);
    end
    sweep("alt");

    // Random tail.
    for (int k = 0; k < 1000; k++) step(1'($urandom_range(0, 1)));
    sweep("rand2");

    @(negedge clk);
    #1;
    chk("sb_drain", 25'(exp_q.size()), 25'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
